// File: rtl/konwersja_arbiter.sv
// rtl/konwersja_arbiter.sv - two-requester round-robin front end for a shared sign-magnitude converter
//
// konwersja: combinational sign-magnitude -> two's complement converter.
//   i_arg     in  BITS  sign-magnitude operand (MSB = sign)
//   o_result  out BITS  two's complement value
//   o_error   out 1     operand is negative zero
//
// konwersja_arbiter: shares one konwersja between two requesters.
//   i_clk, i_rst                   clock, asynchronous active-high reset
//   i_req0/i_arg0/o_ack0           requester 0 handshake (ack = operand latched)
//   i_req1/i_arg1/o_ack1           requester 1 handshake
//   o_valid/o_result/o_error/o_id  registered result, held until i_ready
//   i_ready                        consumer accept (only meaningful while o_valid)
//   o_busy                         high whenever a transaction is in flight
//   o_err_cnt                      saturating count of accepted error results

module konwersja #(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] i_arg,
  output logic [BITS-1:0] o_result,
  output logic            o_error
);

  logic            w_neg;
  logic [BITS-2:0] w_mag;

  assign w_neg = i_arg[BITS-1];
  assign w_mag = i_arg[BITS-2:0];

  always_comb begin
    o_result = i_arg;
    o_error  = 1'b0;
    if (w_neg) begin
      // Negate the magnitude; negative zero naturally wraps to zero.
      o_result = ~{1'b0, w_mag} + BITS'(1);
      o_error  = (w_mag == '0);
    end
  end

endmodule

module konwersja_arbiter #(
  parameter int BITS  = 32,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0,
  input  logic [BITS-1:0]  i_arg0,
  output logic             o_ack0,
  input  logic             i_req1,
  input  logic [BITS-1:0]  i_arg1,
  output logic             o_ack1,
  output logic             o_valid,
  output logic [BITS-1:0]  o_result,
  output logic             o_error,
  output logic             o_id,
  input  logic             i_ready,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [BITS-1:0]  r_operand;
  logic             r_ptr;
  logic             r_ack0;
  logic             r_ack1;
  logic             r_valid;
  logic [BITS-1:0]  r_result;
  logic             r_error;
  logic             r_id;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_any_req;
  logic             w_grant_id;
  logic [BITS-1:0]  w_conv_result;
  logic             w_conv_error;

  assign w_any_req = i_req0 | i_req1;
  // Contention resolved by the pointer; a lone request always wins.
  assign w_grant_id = (i_req0 & i_req1) ? r_ptr : i_req1;

  konwersja #(.BITS(BITS)) u_konwersja (
    .i_arg    (r_operand),
    .o_result (w_conv_result),
    .o_error  (w_conv_error)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_operand <= '0;
      r_ptr     <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_error   <= 1'b0;
      r_id      <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      // Acks are single-cycle pulses issued only on the grant edge.
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_id      <= w_grant_id;
            r_operand <= w_grant_id ? i_arg1 : i_arg0;
            r_ack0    <= ~w_grant_id;
            r_ack1    <= w_grant_id;
            r_state   <= S_CONV;
          end
        end
        S_CONV: begin
          r_result <= w_conv_result;
          r_error  <= w_conv_error;
          r_valid  <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            if (r_error && (r_err_cnt != {CNT_W{1'b1}})) begin
              r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            // The requester not served this round gets priority next.
            r_ptr   <= ~r_id;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ack0    = r_ack0;
  assign o_ack1    = r_ack1;
  assign o_valid   = r_valid;
  assign o_result  = r_result;
  assign o_error   = r_error;
  assign o_id      = r_id;
  assign o_busy    = (r_state != S_IDLE);
  assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_konwersja_arbiter.sv
// tb/tb_konwersja_arbiter.sv - randomized self-checking bench for konwersja_arbiter

module tb_konwersja_arbiter;

  localparam int BITS  = 32;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             req0, req1, ready;
  logic [BITS-1:0]  arg0, arg1;
  logic             ack0, ack1, valid, error, id, busy;
  logic [BITS-1:0]  result;
  logic [CNT_W-1:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int             m_phase;   // 0 free, 1 operand held, 2 result presented
  bit             m_prio;
  logic [BITS-1:0] m_op;
  bit             m_ack0, m_ack1, m_valid, m_err, m_id;
  logic [BITS-1:0] m_res;
  int             m_cnt;

  // requester stimulus state
  bit              t_r0, t_r1, t_rdy, t_hold;
  logic [BITS-1:0] t_a0, t_a1;

  konwersja_arbiter #(.BITS(BITS), .CNT_W(CNT_W)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req0    (req0),
    .i_arg0    (arg0),
    .o_ack0    (ack0),
    .i_req1    (req1),
    .i_arg1    (arg1),
    .o_ack1    (ack1),
    .o_valid   (valid),
    .o_result  (result),
    .o_error   (error),
    .o_id      (id),
    .i_ready   (ready),
    .o_busy    (busy),
    .o_err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BITS-1:0] ref_conv(input logic [BITS-1:0] x);
    logic [BITS-1:0] mag;
    mag = x;
    mag[BITS-1] = 1'b0;
    return x[BITS-1] ? (BITS'(0) - mag) : x;
  endfunction

  function automatic logic [BITS-1:0] rand_arg();
    case ($urandom_range(3))
      0: rand_arg = {1'b1, {(BITS-1){1'b0}}};
      1: rand_arg = BITS'($urandom_range(15)) | {($urandom_range(1) == 1), {(BITS-1){1'b0}}};
      default: rand_arg = $urandom;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_prio = 0; m_op = '0;
    m_ack0 = 0; m_ack1 = 0; m_valid = 0; m_err = 0; m_id = 0; m_res = '0; m_cnt = 0;
  endtask

  task automatic model_step(input bit r0, input logic [BITS-1:0] a0,
                            input bit r1, input logic [BITS-1:0] a1, input bit rdy);
    bit w;
    m_ack0 = 0; m_ack1 = 0;
    if (m_phase == 0) begin
      if (r0 || r1) begin
        w = (r0 && r1) ? m_prio : r1;
        if (w) m_ack1 = 1; else m_ack0 = 1;
        m_op = w ? a1 : a0;
        m_id = w;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_res = ref_conv(m_op);
      m_err = (m_op == {1'b1, {(BITS-1){1'b0}}});
      m_valid = 1;
      m_phase = 2;
    end else if (rdy) begin
      m_valid = 0;
      if (m_err) m_cnt = (m_cnt + 1 > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : m_cnt + 1;
      m_prio = !m_id;
      m_phase = 0;
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, compare at the next falling edge.
  task automatic step();
    req0 = t_r0; arg0 = t_a0; req1 = t_r1; arg1 = t_a1; ready = t_rdy;
    @(posedge clk);
    model_step(t_r0, t_a0, t_r1, t_a1, t_rdy);
    @(negedge clk);
    check("ack0", 64'(ack0), 64'(m_ack0));
    check("ack1", 64'(ack1), 64'(m_ack1));
    check("valid", 64'(valid), 64'(m_valid));
    check("busy", 64'(busy), 64'(m_phase != 0));
    check("err_cnt", 64'(err_cnt), 64'(m_cnt));
    if (m_valid) begin
      check("result", 64'(result), 64'(m_res));
      check("error", 64'(error), 64'(m_err));
      check("id", 64'(id), 64'(m_id));
    end
    if (!t_hold) begin
      if (m_ack0) t_r0 = 0;
      if (m_ack1) t_r1 = 0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called at a falling edge; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_ack0", 64'(ack0), 64'd0);
    check("rst_ack1", 64'(ack1), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_id", 64'(id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cnt", 64'(err_cnt), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0; arg0 = '0; arg1 = '0; ready = 0;
    t_r0 = 0; t_r1 = 0; t_a0 = '0; t_a1 = '0; t_rdy = 1; t_hold = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // single request, known value
    t_r0 = 1; t_a0 = 32'h0000_0005; t_rdy = 1;
    run(4);

    // simultaneous requests from reset alternate 0,1 then 0 again
    do_reset();
    t_r0 = 1; t_a0 = rand_arg(); t_r1 = 1; t_a1 = rand_arg();
    run(7);
    t_r0 = 1; t_a0 = rand_arg(); t_r1 = 1; t_a1 = rand_arg();
    run(7);

    // negative zero from requester 1, counted only on acceptance
    t_r1 = 1; t_a1 = 32'h8000_0000;
    run(4);

    // backpressure with a pending competing request
    t_r1 = 1; t_a1 = rand_arg(); t_rdy = 1;
    run(1);
    t_rdy = 0; t_r0 = 1; t_a0 = rand_arg();
    run(7);
    t_rdy = 1;
    run(5);

    // reset while converting: pointer was 1, after reset it must be 0 again
    t_hold = 1; t_r0 = 1; t_a0 = rand_arg(); t_r1 = 1; t_a1 = rand_arg();
    run(1);
    do_reset();
    run(1);
    t_hold = 0; t_r1 = 0;
    run(4);

    // counter saturation
    do_reset();
    for (int k = 0; k < 4; k++) begin
      t_r0 = 1; t_a0 = 32'h8000_0000;
      run(3);
    end
    run(1);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (!t_r0 && $urandom_range(3) == 0) begin t_r0 = 1; t_a0 = rand_arg(); end
      if (!t_r1 && $urandom_range(3) == 0) begin t_r1 = 1; t_a1 = rand_arg(); end
      t_rdy = ($urandom_range(1) == 1);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
